// File: rtl/pc_sequencer_pkg.sv
// Shared types, widths and default addresses for the fetch PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h0000_00FF;
  localparam logic [XLEN-1:0] DEF_WRAP_PC    = 32'h0000_0FFF;
  localparam int unsigned     DEF_FLUSH_CYC  = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] target;
  } redirect_t;

  // Any candidate at or beyond the wrap point restarts at the reset PC.
  function automatic logic [XLEN-1:0] wrap_pc(input logic [XLEN-1:0] cand,
                                              input logic [XLEN-1:0] wrap_at,
                                              input logic [XLEN-1:0] reset_pc);
    return (cand >= wrap_at) ? reset_pc : cand;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/hazard side and fetch side signals of the PC sequencer.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic            stall;
  redirect_t       branch;
  redirect_t       jump;
  logic            exc_req;
  logic            exc_ret;
  logic [XLEN-1:0] pc;
  logic            pc_valid_c;
  logic            flush;
  logic [XLEN-1:0] epc;
  logic            in_handler;
  logic            double_fault;

  modport master (
    input  stall, branch, jump, exc_req, exc_ret,
    output pc, pc_valid_c, flush, epc, in_handler, double_fault
  );

  modport slave (
    output stall, branch, jump, exc_req, exc_ret,
    input  pc, pc_valid_c, flush, epc, in_handler, double_fault
  );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// Next-PC priority select with redirect alignment check and wrap compare.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] WRAP_PC  = DEF_WRAP_PC
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            in_handler_i,
  input  redirect_t       jump_i,
  input  redirect_t       branch_i,
  input  logic            exc_req_i,
  input  logic            exc_ret_i,
  output logic            fault_c_o,
  output logic            ret_c_o,
  output logic [XLEN-1:0] pc_next_c_o
);

  logic            redir_valid;
  logic [XLEN-1:0] redir_tgt;
  logic            misalign;
  logic [XLEN-1:0] cand;

  // Jump beats branch; only the winning target is checked for alignment.
  always_comb begin
    redir_valid = jump_i.valid | branch_i.valid;
    redir_tgt   = jump_i.valid ? jump_i.target : branch_i.target;
    misalign    = redir_valid & (redir_tgt[1:0] != 2'b00);
    fault_c_o   = exc_req_i | misalign;
    ret_c_o     = exc_ret_i & in_handler_i;
    if (ret_c_o) begin
      cand = epc_i + XLEN'(4);
    end else if (redir_valid) begin
      cand = redir_tgt;
    end else begin
      cand = pc_i + XLEN'(4);
    end
    pc_next_c_o = wrap_pc(cand, WRAP_PC, RESET_PC);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and exception FSM: run, flush bubbles, handler, halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [XLEN-1:0] WRAP_PC    = DEF_WRAP_PC,
  parameter int unsigned     FLUSH_CYC  = DEF_FLUSH_CYC
) (
  input logic                clk,
  input logic                rst_n,
  pc_sequencer_if.master     seq_io
);

  localparam int unsigned CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            in_handler_q, in_handler_d;
  logic            double_fault_q, double_fault_d;

  logic            fault_c;
  logic            ret_c;
  logic [XLEN-1:0] pc_next_c;

  pc_next_mux #(
    .RESET_PC (RESET_PC),
    .WRAP_PC  (WRAP_PC)
  ) u_pc_next_mux (
    .pc_i         (pc_q),
    .epc_i        (epc_q),
    .in_handler_i (state_q == ST_HANDLER),
    .jump_i       (seq_io.jump),
    .branch_i     (seq_io.branch),
    .exc_req_i    (seq_io.exc_req),
    .exc_ret_i    (seq_io.exc_ret),
    .fault_c_o    (fault_c),
    .ret_c_o      (ret_c),
    .pc_next_c_o  (pc_next_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      epc_q          <= '0;
      cnt_q          <= '0;
      flush_q        <= 1'b0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      in_handler_q   <= in_handler_d;
      double_fault_q <= double_fault_d;
    end
  end

  // Exceptions outrank stall; stall outranks every redirect.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epc_d          = epc_q;
    cnt_d          = cnt_q;
    double_fault_d = double_fault_q;
    unique case (state_q)
      ST_RUN, ST_HANDLER: begin
        if (fault_c) begin
          if (state_q == ST_RUN) begin
            epc_d   = pc_q;
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
            state_d = ST_FLUSH;
          end else begin
            double_fault_d = 1'b1;
            state_d        = ST_HALT;
          end
        end else if (ret_c) begin
          pc_d    = pc_next_c;
          state_d = ST_RUN;
        end else if (!seq_io.stall) begin
          pc_d = pc_next_c;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          pc_d    = EXC_VECTOR;
          state_d = ST_HANDLER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
      end
    endcase
    flush_d      = (state_d == ST_FLUSH);
    in_handler_d = (state_d == ST_HANDLER);
  end

  assign seq_io.pc           = pc_q;
  assign seq_io.epc          = epc_q;
  assign seq_io.flush        = flush_q;
  assign seq_io.in_handler   = in_handler_q;
  assign seq_io.double_fault = double_fault_q;
  assign seq_io.pc_valid_c   = ((state_q == ST_RUN) || (state_q == ST_HANDLER)) && !seq_io.stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_EXC_VEC  = 32'h0000_00FF;
  localparam logic [31:0] T_WRAP_PC  = 32'h0000_0FFF;
  localparam int          T_FLUSH    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC   (T_RESET_PC),
    .EXC_VECTOR (T_EXC_VEC),
    .WRAP_PC    (T_WRAP_PC),
    .FLUSH_CYC  (T_FLUSH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_io (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: fetch address, saved PC, remaining bubbles, mode flags.
  logic [31:0] m_pc, m_epc;
  int          m_flush_left;
  bit          m_handler, m_halted, m_df;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrapm(input logic [31:0] a);
    return (a >= T_WRAP_PC) ? T_RESET_PC : a;
  endfunction

  task automatic model_reset();
    m_pc = T_RESET_PC; m_epc = 32'h0; m_flush_left = 0;
    m_handler = 1'b0; m_halted = 1'b0; m_df = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    bit redir, bad;
    if (m_halted) return;
    if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) begin
        m_pc = T_EXC_VEC;
        m_handler = 1'b1;
      end
      return;
    end
    redir = bus.jump.valid || bus.branch.valid;
    tgt   = bus.jump.valid ? bus.jump.target : bus.branch.target;
    bad   = redir && ((tgt % 4) != 0);
    if (bus.exc_req || bad) begin
      if (m_handler) begin
        m_halted = 1'b1; m_df = 1'b1; m_handler = 1'b0;
      end else begin
        m_epc = m_pc;
        m_flush_left = T_FLUSH;
      end
    end else if (bus.exc_ret && m_handler) begin
      m_pc = wrapm(m_epc + 32'd4);
      m_handler = 1'b0;
    end else if (!bus.stall) begin
      m_pc = wrapm(redir ? tgt : m_pc + 32'd4);
    end
  endtask

  task automatic check_state();
    chk("pc", bus.pc, m_pc);
    chk("epc", bus.epc, m_epc);
    chk("flush", 32'(bus.flush), 32'(m_flush_left > 0));
    chk("in_handler", 32'(bus.in_handler), 32'(m_handler));
    chk("double_fault", 32'(bus.double_fault), 32'(m_df));
  endtask

  task automatic drive(input bit st, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit ex, input bit rt);
    bus.stall = st;
    bus.branch.valid = br; bus.branch.target = bt;
    bus.jump.valid = j;    bus.jump.target = jt;
    bus.exc_req = ex;
    bus.exc_ret = rt;
  endtask

  // Called at a negedge: apply inputs, check pc_valid, clock once, check state.
  task automatic step(input bit st, input bit br, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt, input bit ex, input bit rt);
    drive(st, br, bt, j, jt, ex, rt);
    #1;
    chk("pc_valid", 32'(bus.pc_valid_c),
        32'(!m_halted && (m_flush_left == 0) && !st));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 32'hFFF)) | 32'h1;
    if (r == 1) return 32'($urandom) & ~32'h3;
    return 32'($urandom_range(0, 32'h1000)) & ~32'h3;
  endfunction

  initial begin
    int halt_cycles;
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    model_reset();
    #12;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pc_valid", 32'(bus.pc_valid_c), 32'h1);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    idle(); idle();
    chk("t1_pc8", bus.pc, 32'h8);

    // Branch, then jump wins over simultaneous branch.
    step(0, 1, 32'h40, 0, 32'h0, 0, 0);
    chk("t2_branch", bus.pc, 32'h40);
    step(0, 1, 32'h90, 1, 32'h80, 0, 0);
    chk("t2_jump_wins", bus.pc, 32'h80);

    // Stall holds PC and suppresses pc_valid even with a branch pending.
    step(0, 0, 32'h0, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h50, 0, 32'h0, 0, 0);
    chk("t3_stall_hold", bus.pc, 32'h10);
    idle();
    chk("t3_release", bus.pc, 32'h14);

    // Exception entry, two flush bubbles, handler, return.
    step(0, 0, 32'h0, 1, 32'h20, 0, 0);
    step(0, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("t4_epc", bus.epc, 32'h20);
    idle();
    chk("t4_flush2", 32'(bus.flush), 32'h1);
    idle();
    chk("t4_vector", bus.pc, 32'hFF);
    chk("t4_in_handler", 32'(bus.in_handler), 32'h1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 1);
    chk("t4_return", bus.pc, 32'h24);

    // Misaligned jump faults; second fault in the handler halts.
    step(0, 0, 32'h0, 1, 32'h30, 0, 0);
    step(0, 0, 32'h0, 1, 32'h42, 0, 0);
    chk("t5_epc", bus.epc, 32'h30);
    idle(); idle();
    step(0, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("t5_double_fault", 32'(bus.double_fault), 32'h1);
    idle(); idle();
    chk("t5_pc_frozen", bus.pc, 32'hFF);

    // Wrap at the top of the fetch window, then reset in the middle of FLUSH.
    do_reset();
    step(0, 0, 32'h0, 1, 32'hFFC, 0, 0);
    idle();
    chk("t6_wrap", bus.pc, 32'h0);
    idle();
    step(0, 0, 32'h0, 0, 32'h0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pc", bus.pc, 32'h0);
    chk("t6_async_flush", 32'(bus.flush), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_state();

    // Randomized traffic against the model.
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      bit st, br, j, ex, rt;
      if (m_halted) halt_cycles++;
      if (halt_cycles > 3) begin
        halt_cycles = 0;
        do_reset();
      end
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 4) == 0);
      ex = ($urandom_range(0, 24) == 0);
      rt = m_handler ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step(st, br, rnd_tgt(), j, rnd_tgt(), ex, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
